// File: rtl/face_pkg.sv
// Shared constants and state encoding for the face-detection capture path.
package face_pkg;

  localparam int W_DATA     = 8;
  localparam int W_ADDR     = 18;
  localparam int ROW_STRIDE = 512;
  localparam int MAX_ROWS   = 280;

  // Scaled column/row counters need one extra count to hold at the limit.
  localparam int XS_W = 10;
  localparam int YS_W = 9;

  localparam logic [XS_W-1:0] XS_LIMIT = XS_W'(ROW_STRIDE);
  localparam logic [YS_W-1:0] YS_LIMIT = YS_W'(MAX_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_VS     = 2'd1,
    ST_WAIT_VS_END = 2'd2,
    ST_CAPTURE     = 2'd3
  } state_e;

endpackage

// File: rtl/phase_counter.sv
// Modulo-N phase counter; phase_o is the phase of the current cycle and
// wrap_o flags an enabled step out of the last phase.
module phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [2:0] mod_i,
  output logic [2:0] phase_o,
  output logic       wrap_o
);

  logic [2:0] cnt_q, cnt_d;

  // A clear restarts at phase 0 in the same cycle, so that cycle counts as phase 0.
  always_comb begin
    phase_o = clr_i ? 3'd0 : cnt_q;
    wrap_o  = en_i && (phase_o == (mod_i - 3'd1));
    cnt_d   = phase_o;
    if (en_i) begin
      cnt_d = wrap_o ? 3'd0 : phase_o + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_capture.sv
// Camera-domain capture engine: arms on capture_go, subsamples one luma frame
// and writes it to frame-buffer port B with a fixed row stride.
module frame_capture
  import face_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cam_scale,
  input  logic              capture_go,
  input  logic              cam_vsync_i,
  input  logic              cam_href_i,
  input  logic [W_DATA-1:0] cam_data_i,
  output logic              capture_ready,
  output logic [W_ADDR-1:0] ab_frame_buf,
  output logic              cenb_frame_buf,
  output logic [W_DATA-1:0] db_frame_buf
);

  state_e            state_q, state_d;
  logic [2:0]        scale_q, scale_d;
  logic              vsync_q, href_q;
  logic [XS_W-1:0]   xs_q, xs_d, xs_cur;
  logic [YS_W-1:0]   ys_q, ys_d;
  logic              cenb_q, cenb_d;
  logic              ready_q, ready_d;
  logic [W_ADDR-1:0] ab_q, ab_d;
  logic [W_DATA-1:0] db_q, db_d;

  logic       vs_rise, vs_fall, h_rise, h_fall;
  logic       capturing, clr_all, keep;
  logic [2:0] hphase, vphase;
  logic       vwrap, hwrap_unused;

  assign vs_rise = cam_vsync_i & ~vsync_q;
  assign vs_fall = ~cam_vsync_i & vsync_q;
  assign h_rise  = cam_href_i & ~href_q;
  assign h_fall  = ~cam_href_i & href_q;

  // The terminating vsync rise wins over any pixel presented in the same cycle.
  assign capturing = (state_q == ST_CAPTURE) && !vs_rise;
  assign clr_all   = (state_q == ST_WAIT_VS_END) && vs_fall;
  assign xs_cur    = h_rise ? '0 : xs_q;
  assign keep      = capturing && cam_href_i && (hphase == 3'd0) && (vphase == 3'd0);

  phase_counter u_hphase (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_all | h_rise),
    .en_i    (capturing & cam_href_i),
    .mod_i   (scale_q),
    .phase_o (hphase),
    .wrap_o  (hwrap_unused)
  );

  phase_counter u_vphase (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_all),
    .en_i    (capturing & h_fall),
    .mod_i   (scale_q),
    .phase_o (vphase),
    .wrap_o  (vwrap)
  );

  always_comb begin
    state_d = state_q;
    scale_d = scale_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    cenb_d  = 1'b1;
    ready_d = 1'b0;
    ab_d    = ab_q;
    db_d    = db_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_go) begin
          scale_d = (cam_scale == 3'd0) ? 3'd1 : cam_scale;
          state_d = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (vs_rise) state_d = ST_WAIT_VS_END;
      end
      ST_WAIT_VS_END: begin
        if (vs_fall) begin
          xs_d    = '0;
          ys_d    = '0;
          state_d = ST_CAPTURE;
        end
      end
      default: begin
        if (vs_rise) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (cam_href_i) begin
            xs_d = xs_cur;
            if (hphase == 3'd0 && xs_cur < XS_LIMIT) xs_d = xs_cur + XS_W'(1);
            // Out-of-window pixels are dropped; counters hold at their limits.
            if (keep && xs_cur < XS_LIMIT && ys_q < YS_LIMIT) begin
              cenb_d = 1'b0;
              ab_d   = W_ADDR'({ys_q, xs_cur[XS_W-2:0]});
              db_d   = cam_data_i;
            end
          end
          if (vwrap && ys_q < YS_LIMIT) ys_d = ys_q + YS_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      scale_q <= 3'd1;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      xs_q    <= '0;
      ys_q    <= '0;
      cenb_q  <= 1'b1;
      ready_q <= 1'b0;
      ab_q    <= '0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      scale_q <= scale_d;
      vsync_q <= cam_vsync_i;
      href_q  <= cam_href_i;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      cenb_q  <= cenb_d;
      ready_q <= ready_d;
      ab_q    <= ab_d;
      db_q    <= db_d;
    end
  end

  assign capture_ready  = ready_q;
  assign cenb_frame_buf = cenb_q;
  assign ab_frame_buf   = ab_q;
  assign db_frame_buf   = db_q;

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: case table of frames, per-pixel reference model,
// and monitors that log every buffer write and ready pulse with its cycle.
module tb_frame_capture;
  import face_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        cam_scale = 3'd0;
  logic              capture_go = 1'b0;
  logic              cam_vsync_i = 1'b0;
  logic              cam_href_i = 1'b0;
  logic [W_DATA-1:0] cam_data_i = '0;
  logic              capture_ready;
  logic [W_ADDR-1:0] ab_frame_buf;
  logic              cenb_frame_buf;
  logic [W_DATA-1:0] db_frame_buf;

  frame_capture dut (
    .clk            (clk),
    .rst            (rst),
    .cam_scale      (cam_scale),
    .capture_go     (capture_go),
    .cam_vsync_i    (cam_vsync_i),
    .cam_href_i     (cam_href_i),
    .cam_data_i     (cam_data_i),
    .capture_ready  (capture_ready),
    .ab_frame_buf   (ab_frame_buf),
    .cenb_frame_buf (cenb_frame_buf),
    .db_frame_buf   (db_frame_buf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] data;
    int                cyc;
  } wr_t;

  typedef struct {
    int scale;
    int cols;
    int rows;
    bit pattern;
    int mode;       // 0: go before frame, 1: no go, 2: go on the vsync rise
    bit mid_go;
    int rst_pix;    // linear pixel index where rst is pulsed, -1 for none
    bit extra;      // follow with one more frame that must be ignored
    int exp_writes;
    int exp_ready;
  } case_t;

  wr_t exp_w[$];
  wr_t act_w[$];
  int  exp_r[$];
  int  act_r[$];
  int  checks = 0;
  int  failures = 0;

  always @(negedge clk) begin
    if (cenb_frame_buf === 1'b0) act_w.push_back('{ab_frame_buf, db_frame_buf, cyc});
    if (capture_ready === 1'b1) act_r.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_go(input int scale);
    cam_scale  = 3'(scale);
    capture_go = 1'b1;
    tick();
    capture_go = 1'b0;
    cam_scale  = 3'($urandom);
    tick(2);
  endtask

  // Drives vsync pulse then rows; when cap is set, the model predicts each
  // stored pixel from the frame coordinates and the subsample factor.
  task automatic drive_frame(input int scale, input int cols, input int rows, input bit pattern,
                             input bit cap, input bit go_rise, input bit mid_go, input int rst_pix);
    int s;
    bit live;
    s    = (scale == 0) ? 1 : scale;
    live = cap;
    cam_vsync_i = 1'b1;
    capture_go  = go_rise;
    tick();
    capture_go  = 1'b0;
    tick(2);
    cam_vsync_i = 1'b0;
    tick(3);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        cam_href_i = 1'b1;
        cam_data_i = pattern ? 8'(c + 16 * r) : 8'($urandom);
        if (mid_go && r == 1 && c == 0) capture_go = 1'b1;
        if (r * cols + c == rst_pix) begin
          rst  = 1'b1;
          live = 1'b0;
        end
        if (live && (r % s == 0) && (c % s == 0) && (c / s < ROW_STRIDE) && (r / s < MAX_ROWS))
          exp_w.push_back('{W_ADDR'((r / s) * ROW_STRIDE + c / s), cam_data_i, cyc + 1});
        tick();
        capture_go = 1'b0;
        if (rst) begin
          rst = 1'b0;
          @(negedge clk);
          check("rst_drops_write", 32'(cenb_frame_buf), 32'd1);
        end
      end
      cam_href_i = 1'b0;
      tick(4);
    end
  endtask

  task automatic term_vsync(input bit expect_ready);
    cam_vsync_i = 1'b1;
    if (expect_ready) exp_r.push_back(cyc + 1);
    tick(3);
    cam_vsync_i = 1'b0;
    tick(3);
  endtask

  task automatic check_run(input string name, input int exp_writes, input int exp_ready);
    tick(2);
    check({name, "_nwrites"}, 32'(act_w.size()), 32'(exp_writes));
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < act_w.size()) begin
        check({name, "_addr"}, 32'(act_w[i].addr), 32'(exp_w[i].addr));
        check({name, "_data"}, 32'(act_w[i].data), 32'(exp_w[i].data));
        check({name, "_wcyc"}, 32'(act_w[i].cyc), 32'(exp_w[i].cyc));
      end else begin
        check({name, "_missing_write"}, 32'(act_w.size()), 32'(exp_w.size()));
        break;
      end
    end
    check({name, "_nready"}, 32'(act_r.size()), 32'(exp_ready));
    for (int i = 0; i < exp_r.size() && i < act_r.size(); i++)
      check({name, "_ready_cyc"}, 32'(act_r[i]), 32'(exp_r[i]));
    exp_w.delete();
    act_w.delete();
    exp_r.delete();
    act_r.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    case_t cases[12];
    logic [W_ADDR-1:0] s2_addr[8];
    logic [W_DATA-1:0] s2_data[8];
    bit want_ready;

    cases[0]  = '{1, 8,   4,   1, 0, 0, -1, 0, 32,   1};
    cases[1]  = '{2, 8,   4,   1, 0, 0, -1, 0, 8,    1};
    cases[2]  = '{0, 8,   4,   1, 0, 0, -1, 0, 32,   1};
    cases[3]  = '{1, 600, 2,   0, 0, 0, -1, 0, 1024, 1};
    cases[4]  = '{1, 4,   300, 0, 0, 0, -1, 0, 1120, 1};
    cases[5]  = '{3, 10,  7,   0, 0, 0, -1, 0, 12,   1};
    cases[6]  = '{7, 15,  8,   0, 0, 0, -1, 0, 6,    1};
    cases[7]  = '{1, 8,   4,   1, 1, 0, -1, 1, 0,    0};
    cases[8]  = '{1, 6,   3,   0, 0, 1, -1, 1, 18,   1};
    cases[9]  = '{1, 10,  3,   0, 0, 0, 13, 1, 13,   0};
    cases[10] = '{2, 6,   4,   0, 0, 0, -1, 0, 6,    1};
    cases[11] = '{1, 4,   2,   1, 2, 0, -1, 0, 8,    1};

    s2_addr = '{18'd0, 18'd1, 18'd2, 18'd3, 18'd512, 18'd513, 18'd514, 18'd515};
    s2_data = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd32, 8'd34, 8'd36, 8'd38};

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cenb",  32'(cenb_frame_buf), 32'd1);
    check("reset_ab",    32'(ab_frame_buf),   32'd0);
    check("reset_db",    32'(db_frame_buf),   32'd0);
    check("reset_ready", 32'(capture_ready),  32'd0);
    tick(2);

    for (int i = 0; i < 12; i++) begin
      want_ready = (cases[i].mode != 1) && (cases[i].rst_pix < 0);
      case (cases[i].mode)
        0: begin
          pulse_go(cases[i].scale);
          drive_frame(cases[i].scale, cases[i].cols, cases[i].rows, cases[i].pattern,
                      1'b1, 1'b0, cases[i].mid_go, cases[i].rst_pix);
        end
        1: begin
          drive_frame(cases[i].scale, cases[i].cols, cases[i].rows, cases[i].pattern,
                      1'b0, 1'b0, 1'b0, -1);
        end
        default: begin
          cam_scale = 3'(cases[i].scale);
          drive_frame(cases[i].scale, cases[i].cols, cases[i].rows, cases[i].pattern,
                      1'b0, 1'b1, 1'b0, -1);
          cam_scale = 3'($urandom);
          drive_frame(cases[i].scale, cases[i].cols, cases[i].rows, cases[i].pattern,
                      1'b1, 1'b0, 1'b0, -1);
        end
      endcase
      term_vsync(want_ready);
      if (cases[i].extra) begin
        drive_frame(cases[i].scale, cases[i].cols, cases[i].rows, cases[i].pattern,
                    1'b0, 1'b0, 1'b0, -1);
        term_vsync(1'b0);
      end
      if (i == 1) begin
        for (int k = 0; k < 8 && k < act_w.size(); k++) begin
          check("scale2_fixed_addr", 32'(act_w[k].addr), 32'(s2_addr[k]));
          check("scale2_fixed_data", 32'(act_w[k].data), 32'(s2_data[k]));
        end
      end
      check_run($sformatf("case%0d", i), cases[i].exp_writes, cases[i].exp_ready);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
